// File: rtl/me_best_match_pkg.sv
// Shared types and width helpers for the motion-estimation best-match block.
package me_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } me_state_t;

  function automatic int sum_w(input int sad_width, input int pex, input int pey);
    return sad_width + $clog2(pex * pey);
  endfunction

  function automatic int mvx_w(input int search_w);
    return $clog2(search_w) + 1;
  endfunction

  function automatic int mvy_w(input int search_h);
    return $clog2(search_h) + 1;
  endfunction

  localparam int MVX_W_DEF = 4;
  localparam int MVY_W_DEF = 4;

  typedef struct packed {
    logic signed [MVX_W_DEF-1:0] x;
    logic signed [MVY_W_DEF-1:0] y;
  } mv_t;

endpackage

// File: rtl/me_best_match_if.sv
// Candidate-in / result-out bundle of me_best_match, plus the FSM state for observation.
interface me_best_match_if
  import me_pkg::*;
#(
  parameter int SAD_WIDTH = 16,
  parameter int PEX       = 4,
  parameter int PEY       = 4,
  parameter int SEARCH_W  = 8,
  parameter int SEARCH_H  = 8
);

  localparam int SUM_W = sum_w(SAD_WIDTH, PEX, PEY);
  localparam int MVX_W = mvx_w(SEARCH_W);
  localparam int MVY_W = mvy_w(SEARCH_H);

  // Both channels transfer on a rising edge where valid && ready; a holder of valid
  // keeps valid and its payload stable until that edge.
  logic                                  start;
  logic                                  busy;
  logic                                  sad_valid;
  logic                                  sad_ready;
  logic [PEX-1:0][PEY-1:0][SAD_WIDTH-1:0] sad;
  logic                                  res_valid;
  logic                                  res_ready;
  logic [SUM_W-1:0]                      min_sad;
  logic signed [MVX_W-1:0]               mv_x;
  logic signed [MVY_W-1:0]               mv_y;
  logic                                  early_term;
  me_state_t                             state;

  modport master (
    input  start, sad_valid, sad, res_ready,
    output busy, sad_ready, res_valid, min_sad, mv_x, mv_y, early_term, state
  );

  modport slave (
    output start, sad_valid, sad, res_ready,
    input  busy, sad_ready, res_valid, min_sad, mv_x, mv_y, early_term, state
  );

endinterface

// File: rtl/me_best_match_sad_adder_tree.sv
// Combinational sum of all PEX*PEY partial SADs at full SUM_W width.
module sad_adder_tree #(
  parameter int SAD_WIDTH = 16,
  parameter int PEX       = 4,
  parameter int PEY       = 4,
  parameter int SUM_W     = SAD_WIDTH + $clog2(PEX * PEY)
) (
  input  logic [PEX-1:0][PEY-1:0][SAD_WIDTH-1:0] i_sad,
  output logic [SUM_W-1:0]                       o_sum
);

  always_comb begin
    o_sum = '0;
    for (int x = 0; x < PEX; x++) begin
      for (int y = 0; y < PEY; y++) begin
        o_sum = o_sum + SUM_W'(i_sad[x][y]);
      end
    end
  end

endmodule

// File: rtl/me_best_match.sv
// Sums each candidate's partial SADs, keeps the raster-order minimum and returns SAD + MV.
// ME_EARLY_TERM_EN adds threshold-based early termination.
module me_best_match
  import me_pkg::*;
#(
  parameter int SAD_WIDTH    = 16,
  parameter int PEX          = 4,
  parameter int PEY          = 4,
  parameter int SEARCH_W     = 8,
  parameter int SEARCH_H     = 8,
  parameter int EARLY_THRESH = 64
) (
  input  logic            clk,
  input  logic            rst,
  me_best_match_if.master me
);

  localparam int SUM_W = sum_w(SAD_WIDTH, PEX, PEY);
  localparam int MVX_W = mvx_w(SEARCH_W);
  localparam int MVY_W = mvy_w(SEARCH_H);
  localparam int CX_W  = $clog2(SEARCH_W);
  localparam int CY_W  = $clog2(SEARCH_H);

  me_state_t               r_state;
  me_state_t               w_next;
  logic [CX_W-1:0]         r_cx;
  logic [CY_W-1:0]         r_cy;
  logic                    r_first;
  logic                    r_s1_valid;
  logic [SUM_W-1:0]        r_s1_sum;
  logic [CX_W-1:0]         r_s1_cx;
  logic [CY_W-1:0]         r_s1_cy;
  logic [SUM_W-1:0]        r_min_sad;
  logic signed [MVX_W-1:0] r_mv_x;
  logic signed [MVY_W-1:0] r_mv_y;
  logic [SUM_W-1:0]        w_sum;
  logic                    w_sad_ready;
  logic                    w_busy;
  logic                    w_res_valid;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_commit;
  logic                    w_hit;

  sad_adder_tree #(
    .SAD_WIDTH (SAD_WIDTH),
    .PEX       (PEX),
    .PEY       (PEY),
    .SUM_W     (SUM_W)
  ) u_adder (
    .i_sad (me.sad),
    .o_sum (w_sum)
  );

  assign w_accept = me.sad_valid && w_sad_ready;
  assign w_last   = w_accept && (r_cx == CX_W'(SEARCH_W - 1)) && (r_cy == CY_W'(SEARCH_H - 1));
  // The first candidate of a search always loads; later ones only on a strict improvement.
  assign w_commit = r_s1_valid && (r_first || (r_s1_sum < r_min_sad));

`ifdef ME_EARLY_TERM_EN
  logic r_early_term;
  assign w_hit = w_commit && (r_s1_sum < SUM_W'(EARLY_THRESH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_early_term <= 1'b0;
    else if (w_commit) r_early_term <= w_hit;
  end
  assign me.early_term = r_early_term;
`else
  assign w_hit         = 1'b0;
  assign me.early_term = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (me.start) w_next = SEARCH;
      SEARCH:  if (w_hit) w_next = DONE;
               else if (w_last) w_next = FLUSH;
      FLUSH:   w_next = DONE;
      DONE:    if (me.res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A committing early hit withdraws ready in the same cycle so nothing follows it in.
  always_comb begin
    w_sad_ready = 1'b0;
    w_busy      = 1'b1;
    w_res_valid = 1'b0;
    unique case (r_state)
      IDLE:    w_busy = 1'b0;
      SEARCH:  w_sad_ready = !w_hit;
      FLUSH:   w_sad_ready = 1'b0;
      DONE:    w_res_valid = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_first <= 1'b0;
    end else if (r_state == IDLE && me.start) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_first <= 1'b1;
    end else begin
      if (w_accept) begin
        if (r_cx == CX_W'(SEARCH_W - 1)) begin
          r_cx <= '0;
          r_cy <= r_cy + CY_W'(1);
        end else begin
          r_cx <= r_cx + CX_W'(1);
        end
      end
      if (w_commit) r_first <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_cx    <= '0;
      r_s1_cy    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sum <= w_sum;
        r_s1_cx  <= r_cx;
        r_s1_cy  <= r_cy;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min_sad <= '0;
      r_mv_x    <= '0;
      r_mv_y    <= '0;
    end else if (w_commit) begin
      r_min_sad <= r_s1_sum;
      r_mv_x    <= $signed({1'b0, r_s1_cx}) - $signed(MVX_W'(SEARCH_W / 2));
      r_mv_y    <= $signed({1'b0, r_s1_cy}) - $signed(MVY_W'(SEARCH_H / 2));
    end
  end

  assign me.sad_ready = w_sad_ready;
  assign me.busy      = w_busy;
  assign me.res_valid = w_res_valid;
  assign me.min_sad   = r_min_sad;
  assign me.mv_x      = r_mv_x;
  assign me.mv_y      = r_mv_y;
  assign me.state     = r_state;

endmodule

// File: tb/tb_me_best_match.sv
// Self-checking bench for me_best_match: randomized candidates against a raster-order minimum model.
module tb_me_best_match;
  import me_pkg::*;

  localparam int NCAND = 64;
  localparam int NPE   = 16;
  localparam int PEY   = 4;
  localparam int RW    = 29;

  logic clk = 1'b0;
  logic rst = 1'b0;

  me_best_match_if bus ();

  me_best_match dut (
    .clk (clk),
    .rst (rst),
    .me  (bus)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [RW-1:0] exp_q[$];
  logic [15:0]   pat [NCAND][NPE];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_const(input int v);
    for (int i = 0; i < NCAND; i++)
      for (int k = 0; k < NPE; k++) pat[i][k] = 16'(v);
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < NCAND; i++)
      for (int k = 0; k < NPE; k++) pat[i][k] = 16'($urandom_range(hi, lo));
  endtask

  task automatic fill_cand(input int idx, input int v);
    for (int k = 0; k < NPE; k++) pat[idx][k] = 16'(v);
  endtask

  function automatic int cand_sum(input int i);
    int s;
    s = 0;
    for (int k = 0; k < NPE; k++) s += int'(pat[i][k]);
    return s;
  endfunction

  // Reference: scan candidates in raster order, keep the first strict minimum.
  task automatic model_search(output int n_acc);
    int best;
    int bidx;
    bit early;
    best  = 0;
    bidx  = 0;
    early = 1'b0;
    n_acc = NCAND;
    for (int i = 0; i < NCAND; i++) begin
      int s;
      s = cand_sum(i);
      if (i == 0 || s < best) begin
        best = s;
        bidx = i;
`ifdef ME_EARLY_TERM_EN
        if (s < 64) begin
          early = 1'b1;
          n_acc = i + 1;
          break;
        end
`endif
      end
    end
    exp_q.push_back({early, 20'(best), 4'(bidx % 8 - 4), 4'(bidx / 8 - 4)});
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap_pct, input bit noise, output int got);
    int guard;
    bit acc;
    got   = 0;
    guard = 0;
    while (got < n && guard < 4000) begin
      bus.sad_valid = ($urandom_range(99) >= gap_pct);
      for (int k = 0; k < NPE; k++) bus.sad[k / PEY][k % PEY] = pat[got][k];
      bus.start = noise && ($urandom_range(7) == 0);
      acc = bus.sad_valid && bus.sad_ready;
      @(posedge clk); #1;
      if (acc) got++;
      guard++;
    end
    bus.sad_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic finish_result();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.sad_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sad_ready: got %0b want 0", bus.sad_ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %0b want 0", bus.res_valid); end
    n_tests++; if (bus.min_sad !== 20'd0) begin n_fail++; $display("FAIL reset_min_sad: got %h want 0", bus.min_sad); end
    n_tests++; if (bus.mv_x !== 4'sd0 || bus.mv_y !== 4'sd0) begin n_fail++; $display("FAIL reset_mv: got %0d,%0d want 0,0", bus.mv_x, bus.mv_y); end
    n_tests++; if (bus.early_term !== 1'b0) begin n_fail++; $display("FAIL reset_early_term: got %0b want 0", bus.early_term); end
    n_tests++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", bus.state); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_min();
    int n, got;
    logic [RW-1:0] exp;
    fill_const(10);
    fill_cand(29, 1);
    model_search(n);
    exp = exp_q.pop_front();
    pulse_start();
    n_tests++; if (bus.busy !== 1'b1 || bus.sad_ready !== 1'b1) begin n_fail++; $display("FAIL single_start: busy=%0b sad_ready=%0b want 1/1", bus.busy, bus.sad_ready); end
    feed(n, 0, 1'b0, got);
    n_tests++; if (got !== n) begin n_fail++; $display("FAIL single_accepts: got %0d want %0d", got, n); end
    n_tests++; if (bus.res_valid !== 1'b0 || bus.sad_ready !== 1'b0) begin n_fail++; $display("FAIL single_t1: res_valid=%0b sad_ready=%0b want 0/0", bus.res_valid, bus.sad_ready); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: res_valid=%0b want 1", bus.res_valid); end
    n_tests++; if ({bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y} !== exp) begin n_fail++; $display("FAIL single_result: got %h want %h", {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y}, exp); end
    finish_result();
    n_tests++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_release: res_valid=%0b busy=%0b want 0/0", bus.res_valid, bus.busy); end
  endtask

  task automatic test_tie();
    int n, got;
    logic [RW-1:0] exp;
    fill_rand(4, 200);
    fill_cand(2, 2);
    fill_cand(54, 2);
    model_search(n);
    exp = exp_q.pop_front();
    pulse_start();
    feed(n, 0, 1'b0, got);
    n_tests++; if (got !== n) begin n_fail++; $display("FAIL tie_accepts: got %0d want %0d", got, n); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL tie_latency: res_valid=%0b want 1", bus.res_valid); end
    n_tests++; if ({bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y} !== exp) begin n_fail++; $display("FAIL tie_result: got %h want %h", {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y}, exp); end
    finish_result();
  endtask

  task automatic test_saturate();
    int n, got;
    logic [RW-1:0] exp;
    fill_const(16'hFFFF);
    model_search(n);
    exp = exp_q.pop_front();
    pulse_start();
    feed(n, 0, 1'b0, got);
    n_tests++; if (got !== n) begin n_fail++; $display("FAIL sat_accepts: got %0d want %0d", got, n); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL sat_latency: res_valid=%0b want 1", bus.res_valid); end
    n_tests++; if ({bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y} !== exp) begin n_fail++; $display("FAIL sat_result: got %h want %h", {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y}, exp); end
    finish_result();
  endtask

  task automatic test_early_term();
    int n, got;
    logic [RW-1:0] exp;
    fill_const(10);
    for (int k = 0; k < NPE; k++) pat[9][k] = (k < 8) ? 16'd3 : 16'd2;
    model_search(n);
    exp = exp_q.pop_front();
    pulse_start();
    feed(n, 0, 1'b0, got);
    n_tests++; if (got !== n) begin n_fail++; $display("FAIL early_accepts: got %0d want %0d", got, n); end
    n_tests++; if (bus.sad_ready !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL early_t1: sad_ready=%0b res_valid=%0b want 0/0", bus.sad_ready, bus.res_valid); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL early_latency: res_valid=%0b want 1", bus.res_valid); end
    n_tests++; if ({bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y} !== exp) begin n_fail++; $display("FAIL early_result: got %h want %h", {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y}, exp); end
    finish_result();
  endtask

  task automatic test_random_gaps();
    int n, got;
    logic [RW-1:0] exp;
    fill_rand(4, 4095);
    model_search(n);
    exp = exp_q.pop_front();
    pulse_start();
    feed(n, 30, 1'b1, got);
    n_tests++; if (got !== n) begin n_fail++; $display("FAIL gaps_accepts: got %0d want %0d", got, n); end
    n_tests++; if (bus.sad_ready !== 1'b0) begin n_fail++; $display("FAIL gaps_extra_accept: sad_ready=%0b want 0", bus.sad_ready); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_latency: res_valid=%0b want 1", bus.res_valid); end
    for (int c = 0; c < 10; c++) begin
      bus.start = ($urandom_range(1) == 1);
      @(posedge clk); #1;
      n_tests++; if (bus.res_valid !== 1'b1 || {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y} !== exp) begin n_fail++; $display("FAIL gaps_hold[%0d]: valid=%0b got %h want 1/%h", c, bus.res_valid, {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y}, exp); end
    end
    bus.start = 1'b0;
    finish_result();
    n_tests++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL gaps_release: res_valid=%0b busy=%0b want 0/0", bus.res_valid, bus.busy); end
  endtask

  task automatic test_back_to_back();
    int n, got;
    logic [RW-1:0] exp;
    fill_rand(4, 4095);
    model_search(n);
    exp = exp_q.pop_front();
    pulse_start();
    n_tests++; if (bus.busy !== 1'b1 || bus.sad_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_start: busy=%0b sad_ready=%0b want 1/1", bus.busy, bus.sad_ready); end
    feed(n, 15, 1'b1, got);
    n_tests++; if (got !== n) begin n_fail++; $display("FAIL b2b_accepts: got %0d want %0d", got, n); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b1 || {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y} !== exp) begin n_fail++; $display("FAIL b2b_result: valid=%0b got %h want 1/%h", bus.res_valid, {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y}, exp); end
    finish_result();
  endtask

  task automatic test_reset_mid();
    int n, got;
    logic [RW-1:0] exp;
    fill_rand(4, 4095);
    pulse_start();
    feed(20, 20, 1'b0, got);
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.sad_ready !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: busy=%0b sad_ready=%0b res_valid=%0b want 0/0/0", bus.busy, bus.sad_ready, bus.res_valid); end
    n_tests++; if ({bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y} !== '0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y}); end
    n_tests++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want IDLE", bus.state); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result[%0d]: res_valid=%0b want 0", c, bus.res_valid); end
    end
    fill_rand(4, 4095);
    model_search(n);
    exp = exp_q.pop_front();
    pulse_start();
    feed(n, 10, 1'b0, got);
    n_tests++; if (got !== n) begin n_fail++; $display("FAIL midrst_accepts: got %0d want %0d", got, n); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b1 || {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y} !== exp) begin n_fail++; $display("FAIL midrst_result: valid=%0b got %h want 1/%h", bus.res_valid, {bus.early_term, bus.min_sad, bus.mv_x, bus.mv_y}, exp); end
    finish_result();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad       = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single_min();
    test_tie();
    test_saturate();
    test_early_term();
    test_random_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
